// File: rtl/tl_ul_inflight_tracker.sv
// Passive TL-UL checker: tracks in-flight requests per source ID and reports
// protocol faults as a one-cycle pulse with a code, plus a sticky flag.
module tl_ul_inflight_tracker #(
    parameter int SRC_W      = 3,
    parameter int BEAT_BYTES = 4,
    parameter int MAX_SIZE   = 6,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             a_valid,
    input  logic             a_ready,
    input  logic [2:0]       a_opcode,
    input  logic [2:0]       a_size,
    input  logic [SRC_W-1:0] a_source,
    input  logic             d_valid,
    input  logic             d_ready,
    input  logic [2:0]       d_opcode,
    input  logic [2:0]       d_size,
    input  logic [SRC_W-1:0] d_source,
    output logic [SRC_W:0]   outstanding,
    output logic             err_valid,
    output logic [2:0]       err_code,
    output logic [SRC_W-1:0] err_source,
    output logic             err_sticky
);

    localparam int NSRC   = 1 << SRC_W;
    localparam int LOG2BB = $clog2(BEAT_BYTES);
    localparam int WD_W   = $clog2(TIMEOUT + 1);

    localparam logic [2:0] A_PUTFULL = 3'd0;
    localparam logic [2:0] A_PUTPART = 3'd1;
    localparam logic [2:0] A_GET     = 3'd4;
    localparam logic [2:0] D_ACKDATA = 3'd1;

    localparam logic [2:0] E_DUP     = 3'd1;
    localparam logic [2:0] E_UNEXP   = 3'd2;
    localparam logic [2:0] E_DMISM   = 3'd3;
    localparam logic [2:0] E_BADOP   = 3'd4;
    localparam logic [2:0] E_BURST   = 3'd5;
    localparam logic [2:0] E_TIMEOUT = 3'd6;

    // Number of beats after the first one for a transfer of 2**size bytes.
    function automatic logic [4:0] beats_m1(input logic [2:0] size);
        int n;
        if (int'(size) <= LOG2BB) n = 1;
        else                      n = 1 << (int'(size) - LOG2BB);
        return 5'(n - 1);
    endfunction

    function automatic logic a_legal(input logic [2:0] op, input logic [2:0] size);
        return ((op == A_PUTFULL) || (op == A_PUTPART) || (op == A_GET)) &&
               (int'(size) <= MAX_SIZE);
    endfunction

    function automatic logic [SRC_W:0] popcount(input logic [NSRC-1:0] v);
        logic [SRC_W:0] c;
        c = '0;
        for (int i = 0; i < NSRC; i++) c = c + {{SRC_W{1'b0}}, v[i]};
        return c;
    endfunction

    logic [NSRC-1:0]        valid_q,  valid_d;
    logic [NSRC-1:0]        exp_op_q, exp_op_d;
    logic [NSRC-1:0][2:0]   size_q,   size_d;
    logic [4:0]             a_cnt_q,  a_cnt_d;
    logic [SRC_W-1:0]       a_src_q,  a_src_d;
    logic [2:0]             a_op_q,   a_op_d;
    logic [2:0]             a_size_q, a_size_d;
    logic [4:0]             d_cnt_q,  d_cnt_d;
    logic [SRC_W-1:0]       d_src_q,  d_src_d;
    logic                   d_hit_q,  d_hit_d;
    logic [WD_W-1:0]        wd_q,     wd_d;
    logic [SRC_W:0]         outstanding_q, outstanding_d;
    logic                   err_valid_q;
    logic [2:0]             err_code_q, err_code_d;
    logic [SRC_W-1:0]       err_source_q, err_source_d;
    logic                   err_sticky_q;

    logic                   a_fire, d_fire;
    logic                   d_hit_now;
    logic [4:0]             d_first_cnt;
    logic [6:1]             fault;
    logic                   err_any;
    logic [SRC_W-1:0]       to_src;

    assign a_fire = a_valid & a_ready;
    assign d_fire = d_valid & d_ready;

    always_comb begin
        valid_d      = valid_q;
        exp_op_d     = exp_op_q;
        size_d       = size_q;
        a_cnt_d      = a_cnt_q;
        a_src_d      = a_src_q;
        a_op_d       = a_op_q;
        a_size_d     = a_size_q;
        d_cnt_d      = d_cnt_q;
        d_src_d      = d_src_q;
        d_hit_d      = d_hit_q;
        wd_d         = wd_q;
        fault        = '0;
        d_hit_now    = 1'b0;
        d_first_cnt  = '0;
        to_src       = '0;
        err_code_d   = err_code_q;
        err_source_d = err_source_q;

        // D channel is evaluated first so a retiring entry frees its slot
        // before a same-cycle A allocation looks at it.
        if (d_fire) begin
            if (d_cnt_q == 5'd0) begin
                d_hit_now   = valid_q[d_source];
                d_first_cnt = (d_opcode == D_ACKDATA) ? beats_m1(d_size) : 5'd0;
                if (!d_hit_now) begin
                    fault[2] = 1'b1;
                end else if ((d_opcode != {2'b00, exp_op_q[d_source]}) ||
                             (d_size != size_q[d_source])) begin
                    fault[3] = 1'b1;
                end
                d_cnt_d = d_first_cnt;
                d_src_d = d_source;
                d_hit_d = d_hit_now;
                if ((d_first_cnt == 5'd0) && d_hit_now) valid_d[d_source] = 1'b0;
            end else begin
                d_cnt_d = d_cnt_q - 5'd1;
                if ((d_cnt_q == 5'd1) && d_hit_q) valid_d[d_src_q] = 1'b0;
            end
        end

        if (a_fire) begin
            if (a_cnt_q != 5'd0) begin
                a_cnt_d = a_cnt_q - 5'd1;
                if ((a_source != a_src_q) || (a_opcode != a_op_q) || (a_size != a_size_q))
                    fault[5] = 1'b1;
            end else if (!a_legal(a_opcode, a_size)) begin
                fault[4] = 1'b1;
            end else begin
                // Burst is tracked even on a duplicate so trailing beats are not
                // misread as fresh requests.
                a_cnt_d  = (a_opcode == A_GET) ? 5'd0 : beats_m1(a_size);
                a_src_d  = a_source;
                a_op_d   = a_opcode;
                a_size_d = a_size;
                if (valid_d[a_source]) begin
                    fault[1] = 1'b1;
                end else begin
                    valid_d[a_source]  = 1'b1;
                    exp_op_d[a_source] = (a_opcode == A_GET);
                    size_d[a_source]   = a_size;
                end
            end
        end

        if (d_fire || (outstanding_q == '0)) begin
            wd_d = '0;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
            wd_d     = '0;
            fault[6] = 1'b1;
        end else begin
            wd_d = wd_q + WD_W'(1);
        end

        // Timeout is attributed to the lowest in-flight source.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (valid_q[i]) to_src = SRC_W'(i);
        end

        err_any = |fault;
        if (fault[1]) begin
            err_code_d   = E_DUP;
            err_source_d = a_source;
        end else if (fault[2]) begin
            err_code_d   = E_UNEXP;
            err_source_d = d_source;
        end else if (fault[3]) begin
            err_code_d   = E_DMISM;
            err_source_d = d_source;
        end else if (fault[4]) begin
            err_code_d   = E_BADOP;
            err_source_d = a_source;
        end else if (fault[5]) begin
            err_code_d   = E_BURST;
            err_source_d = a_source;
        end else if (fault[6]) begin
            err_code_d   = E_TIMEOUT;
            err_source_d = to_src;
        end

        outstanding_d = popcount(valid_d);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q       <= '0;
            exp_op_q      <= '0;
            size_q        <= '0;
            a_cnt_q       <= '0;
            a_src_q       <= '0;
            a_op_q        <= '0;
            a_size_q      <= '0;
            d_cnt_q       <= '0;
            d_src_q       <= '0;
            d_hit_q       <= 1'b0;
            wd_q          <= '0;
            outstanding_q <= '0;
            err_valid_q   <= 1'b0;
            err_code_q    <= '0;
            err_source_q  <= '0;
            err_sticky_q  <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            exp_op_q      <= exp_op_d;
            size_q        <= size_d;
            a_cnt_q       <= a_cnt_d;
            a_src_q       <= a_src_d;
            a_op_q        <= a_op_d;
            a_size_q      <= a_size_d;
            d_cnt_q       <= d_cnt_d;
            d_src_q       <= d_src_d;
            d_hit_q       <= d_hit_d;
            wd_q          <= wd_d;
            outstanding_q <= outstanding_d;
            err_valid_q   <= err_any;
            err_code_q    <= err_code_d;
            err_source_q  <= err_source_d;
            err_sticky_q  <= err_sticky_q | err_any;
        end
    end

    assign outstanding = outstanding_q;
    assign err_valid   = err_valid_q;
    assign err_code    = err_code_q;
    assign err_source  = err_source_q;
    assign err_sticky  = err_sticky_q;

endmodule
